// File: rtl/avalon_pio_out_blink_pkg.sv
// ----------------------------------------------------------------------------
// avalon_pio_pkg
// Shared definitions for the Avalon-MM blinking PIO output port:
//   - word offsets of the register map
//   - STATUS register bit positions
//   - helper that assembles the STATUS read word
// ----------------------------------------------------------------------------
package avalon_pio_pkg;

    // Register map, word offsets on the 3-bit address bus
    localparam logic [2:0] PIO_DATA   = 3'd0;
    localparam logic [2:0] PIO_SET    = 3'd1;
    localparam logic [2:0] PIO_CLR    = 3'd2;
    localparam logic [2:0] PIO_TGL    = 3'd3;
    localparam logic [2:0] PIO_BLINK  = 3'd4;
    localparam logic [2:0] PIO_PERIOD = 3'd5;
    localparam logic [2:0] PIO_STATUS = 3'd6;
    localparam logic [2:0] PIO_RSVD   = 3'd7;

    // STATUS bit positions
    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_RUN_BIT   = 1;

    // STATUS word: current blink phase and whether the timer is running
    function automatic logic [31:0] status_word(input logic phase, input logic running);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[STATUS_PHASE_BIT] = phase;
        w[STATUS_RUN_BIT]   = running;
        return w;
    endfunction

endpackage

// File: rtl/avalon_pio_out_blink_if.sv
// ----------------------------------------------------------------------------
// avalon_pio_out_blink_if
// Avalon-MM slave bus bundle for the blinking PIO output port.
//   address    : word address (3 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : 32-bit write data
//   readdata   : 32-bit combinational read data
// Modports: master (interconnect / bench side), slave (PIO side).
// ----------------------------------------------------------------------------
interface avalon_pio_out_blink_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/avalon_pio_out_blink_timer.sv
// ----------------------------------------------------------------------------
// pio_blink_timer
// Programmable half-period timer producing the blink phase.
//   clk, reset_n : clock, asynchronous active-low reset
//   period       : half-period in clk cycles; 0 halts the timer with phase 0
//   restart      : forces cnt and phase to 0 (takes priority over counting)
//   phase        : registered blink phase, toggles every `period` cycles
// ----------------------------------------------------------------------------
module pio_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_r;
    logic                phase_r;
    logic                halted_s;
    logic                expire_s;

    // Expiry compare; period - 1 is only meaningful when period is non-zero
    always_comb begin
        halted_s = (period == {PERIOD_W{1'b0}});
        if (halted_s) begin
            expire_s = 1'b0;
        end else begin
            expire_s = (cnt_r == (period - PERIOD_W'(1)));
        end
    end

    // Half-period counter and phase flip-flop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= 1'b0;
        end else if (restart || halted_s) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= 1'b0;
        end else if (expire_s) begin
            cnt_r   <= {PERIOD_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            cnt_r   <= cnt_r + PERIOD_W'(1);
            phase_r <= phase_r;
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/avalon_pio_out_blink.sv
// ----------------------------------------------------------------------------
// avalon_pio_out_blink
// Zero-wait-state Avalon-MM output port with atomic set/clear/toggle and
// per-bit hardware blink.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : Avalon-MM slave (address, chipselect, write_n,
//                  writedata, readdata)
//   out_port     : WIDTH output lines = DATA ^ (BLINK_EN & phase)
// ----------------------------------------------------------------------------
module avalon_pio_out_blink
    import avalon_pio_pkg::*;
#(
    parameter int                  WIDTH        = 9,
    parameter int                  PERIOD_W     = 24,
    parameter logic [WIDTH-1:0]    RESET_VALUE  = '0,
    parameter logic [PERIOD_W-1:0] RESET_PERIOD = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    avalon_pio_out_blink_if.slave   bus,
    output logic [WIDTH-1:0]        out_port
);

    logic [WIDTH-1:0]    data_r;
    logic [WIDTH-1:0]    blink_r;
    logic [PERIOD_W-1:0] period_r;
    logic                phase_s;
    logic                wr_s;
    logic                restart_s;
    logic [WIDTH-1:0]    wd_data_s;
    logic [PERIOD_W-1:0] wd_period_s;
    logic [31:0]         rd_s;
    logic                unused_wd_s;

    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign wd_data_s   = bus.writedata[WIDTH-1:0];
    assign wd_period_s = bus.writedata[PERIOD_W-1:0];
    assign restart_s   = wr_s & (bus.address == PIO_PERIOD);

    // Upper writedata bits are don't-care for narrow fields
    assign unused_wd_s = ^bus.writedata;

    // Register file: DATA with atomic set/clear/toggle, BLINK_EN, PERIOD
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r   <= RESET_VALUE;
            blink_r  <= {WIDTH{1'b0}};
            period_r <= RESET_PERIOD;
        end else if (wr_s) begin
            case (bus.address)
                PIO_DATA:   data_r   <= wd_data_s;
                PIO_SET:    data_r   <= data_r | wd_data_s;
                PIO_CLR:    data_r   <= data_r & ~wd_data_s;
                PIO_TGL:    data_r   <= data_r ^ wd_data_s;
                PIO_BLINK:  blink_r  <= wd_data_s;
                PIO_PERIOD: period_r <= wd_period_s;
                default: begin
                    data_r   <= data_r;
                    blink_r  <= blink_r;
                    period_r <= period_r;
                end
            endcase
        end else begin
            data_r   <= data_r;
            blink_r  <= blink_r;
            period_r <= period_r;
        end
    end

    // A PERIOD write restarts the timer on the same edge it lands
    pio_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_r),
        .restart (restart_s),
        .phase   (phase_s)
    );

    // Read mux, zero-extended; SET/CLEAR/TOGGLE read back DATA
    always_comb begin
        rd_s = 32'h0000_0000;
        case (bus.address)
            PIO_DATA, PIO_SET, PIO_CLR, PIO_TGL: rd_s[WIDTH-1:0]    = data_r;
            PIO_BLINK:                           rd_s[WIDTH-1:0]    = blink_r;
            PIO_PERIOD:                          rd_s[PERIOD_W-1:0] = period_r;
            PIO_STATUS: rd_s = status_word(phase_s, (period_r != {PERIOD_W{1'b0}}));
            PIO_RSVD:                            rd_s = 32'h0000_0000;
            default:                             rd_s = 32'h0000_0000;
        endcase
    end

    assign bus.readdata = rd_s;

    // Output lines are a pure function of registers, so reset acts immediately
    assign out_port = data_r ^ (blink_r & {WIDTH{phase_s}});

endmodule

// File: doc/avalon_pio_out_blink.md
# avalon_pio_out_blink

Parametrised Avalon-MM memory-mapped output port that drives a bank of `WIDTH` general-purpose output lines, such as board LEDs or 7-segment segments. It adds atomic set, clear and toggle registers plus a per-bit hardware blink mode. Blink timing comes from a programmable half-period counter. It sits on the Avalon-MM interconnect as a zero-wait-state slave with combinational read data.

## Interface
- `WIDTH`, 9: number of output lines, 1..32.
- `PERIOD_W`, 24: width of the blink half-period register and counter, 1..32.
- `RESET_VALUE`, 0: reset value of DATA, `WIDTH` bits.
- `RESET_PERIOD`, 0: reset value of PERIOD, `PERIOD_W` bits.

Ports:
- `clk`, in, 1: clock; all state on rising edge.
- `reset_n`, in, 1: reset, asynchronous, active-low.
- `address`, in, 3: word address.
- `chipselect`, in, 1: slave select.
- `write_n`, in, 1: active-low write strobe; a write occurs when `chipselect` is 1 and `write_n` is 0.
- `writedata`, in, 32: write data; bits above the target field are ignored.
- `readdata`, out, 32: combinational read data, zero-extended.
- `out_port`, out, `WIDTH`: driven output lines.

## Operation

Register map (word offsets):

| Offset | Name | Access | Write effect | Read value |
|---|---|---|---|---|
| 0 | DATA | RW | DATA <= writedata[WIDTH-1:0] | DATA |
| 1 | SET | W | DATA <= DATA \| wd | DATA |
| 2 | CLEAR | W | DATA <= DATA & ~wd | DATA |
| 3 | TOGGLE | W | DATA <= DATA ^ wd | DATA |
| 4 | BLINK_EN | RW | per-bit blink enable | BLINK_EN |
| 5 | PERIOD | RW | half-period in clk cycles; also restarts timer (cnt <= 0, phase <= 0) | PERIOD |
| 6 | STATUS | R | ignored | bit0 = phase, bit1 = (PERIOD != 0), other bits 0 |
| 7 | — | — | ignored | 0 |

- Output function: `out_port` = DATA ^ (BLINK_EN & {WIDTH{phase}}).
- Blink timer, `cnt` of width `PERIOD_W`, runs every cycle:
  - PERIOD == 0: `cnt` <= 0, `phase` <= 0. Blinking is halted and `out_port` equals DATA.
  - Else, `cnt` == PERIOD-1: `cnt` <= 0 and `phase` toggles.
  - Else: `cnt` <= `cnt`+1.
  - A PERIOD write overrides the timer update in the same cycle.
- Read and write share one bus cycle. A read never has side effects.

## Timing
- Reset values, applied asynchronously: DATA = `RESET_VALUE`, BLINK_EN = 0, PERIOD = `RESET_PERIOD`, `cnt` = 0, `phase` = 0.
  - Resulting outputs: `out_port` = `RESET_VALUE`, `readdata` follows the address decode.
  - Reset mid-blink returns to these values immediately, with no glitch hold-off.
- Writes update registers on the rising edge where the write is sampled. `out_port` reflects the new DATA, BLINK_EN or restarted phase from that same edge (zero added latency).
- `readdata` is combinational from `address` and register state. It is valid in the same cycle; there is no wait state and no `readdatavalid`.
- Timer expiry in the same cycle as a DATA, SET, CLEAR, TOGGLE or BLINK_EN write: both take effect. `out_port` uses the new DATA and the toggled phase.
- With PERIOD = P > 0, `phase` toggles every P cycles, so the blink square wave period is 2P.
  - P = 1 toggles every cycle.
  - `cnt` wraps from P-1 to 0. It never reaches P unless PERIOD is written smaller than `cnt`; that case is prevented by the restart on PERIOD write.

## Structure
- The shared package `avalon_pio_pkg` holds:
  - register offset constants `PIO_DATA`, `PIO_SET`, `PIO_CLR`, `PIO_TGL`, `PIO_BLINK`, `PIO_PERIOD`, `PIO_STATUS`;
  - the STATUS bit indices.
- Sub-module `pio_blink_timer` (params `PERIOD_W`):
  - inputs `period`, `restart`;
  - output `phase`;
  - owns `cnt`.
- The top level holds address decode, the DATA/BLINK_EN/PERIOD registers, the read mux and the output XOR.

## Test plan
- Reset with `RESET_VALUE` = 9'h0A5 -> `out_port` = 0x0A5, read offset 0 = 0x000000A5, STATUS = 0.
- DATA = 0x0F0, SET 0x00F, CLEAR 0x030, TOGGLE 0x101 -> `out_port` after each edge = 0x0FF, 0x0CF, 0x1CE; reads at offsets 1–3 return DATA.
- DATA = 0, BLINK_EN = 0x003, PERIOD = 4 -> bits[1:0] read 0 for 4 cycles, then 3 for 4 cycles, repeating; STATUS bit0 tracks `phase`; bits[8:2] stay 0.
- Mid-blink, write PERIOD = 0 -> `out_port` = DATA on the next edge; STATUS = 0. Then write PERIOD = 1 -> bits toggle every cycle.
- Assert `reset_n` low during a blink with phase = 1 -> `out_port` returns to `RESET_VALUE` without waiting for `clk`. After release, the first toggle occurs P cycles later.
- Write to offset 7 and to offset 6 with `chipselect` = 0 -> no register changes; offset 7 reads 0.
